stdlib_rr_arbiter_enc: RTL

Round-robin arbiter with a one-entry registered output slot. It sits directly upstream of the one-hot-to-binary encode stage: it selects one of N valid/ready requesters, stores a one-hot grant vector, and drives the encoded winner index (`OHToUInt` of that grant) alongside the payload. Consumers get the winning data, its one-hot grant and its binary index, all aligned in the same registered cycle.

---
 rtl/stdlib_rr_arbiter_enc.sv | 120 ++++++++++++
 1 files changed

// File: rtl/stdlib_rr_arbiter_enc.sv
`default_nettype none
// ============================================================================
//  Module      : stdlib_rr_arbiter_enc
//  Description : Round-robin arbiter over N valid/ready requesters feeding a
//                one-entry registered output slot. The slot carries the
//                winning payload, its one-hot grant and the binary index
//                (OR-reduction encode of the grant), all aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module stdlib_rr_arbiter_enc #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     io_in_valid,
    output logic [N-1:0]     io_in_ready,
    input  logic [N*W-1:0]   io_in_bits,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [W-1:0]     io_out_bits,
    output logic [N-1:0]     io_out_grant_oh,
    output logic [CW-1:0]    io_out_chosen
);

    // Output slot and round-robin pointer
    logic             r_v;
    logic [W-1:0]     r_bits;
    logic [N-1:0]     r_oh;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    r_last;

    logic             w_load;
    logic             w_fire;
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_masked;
    logic [N-1:0]     w_grant;
    logic [W-1:0]     w_bits;
    logic [CW-1:0]    w_enc;

    // Lowest set bit of a vector as a one-hot value (zero if none set)
    function automatic logic [N-1:0] f_first_set(input logic [N-1:0] vec);
        logic [N-1:0] res;
        logic         found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    // One-hot to binary: each index bit is the OR of grant lines whose index has that bit set
    function automatic logic [CW-1:0] f_encode(input logic [N-1:0] oh);
        logic [CW-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                res = res | CW'(i);
            end
        end
        return res;
    endfunction

    // Requesters strictly above the last winner get first pick; otherwise wrap to the bottom
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (CW'(i) > r_last);
        end
        w_masked = io_in_valid & w_mask;
        w_grant  = (|w_masked) ? f_first_set(w_masked) : f_first_set(io_in_valid);
    end

    // Payload of the granted requester; grant is one-hot so an OR-mux suffices
    always_comb begin
        w_bits = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_bits = w_bits | io_in_bits[i*W +: W];
            end
        end
    end

    // Slot can accept when empty or draining this cycle
    assign w_load      = !r_v || io_out_ready;
    assign w_fire      = w_load && (|w_grant);
    assign w_enc       = f_encode(w_grant);
    assign io_in_ready = (w_load && !reset) ? w_grant : '0;

    // Slot update: fill on fire, empty on an idle load, hold on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v    <= 1'b0;
            r_bits <= '0;
            r_oh   <= '0;
            r_idx  <= '0;
            r_last <= CW'(N - 1);
        end else if (w_fire) begin
            r_v    <= 1'b1;
            r_bits <= w_bits;
            r_oh   <= w_grant;
            r_idx  <= w_enc;
            r_last <= w_enc;
        end else if (w_load) begin
            r_v    <= 1'b0;
        end
    end

    assign io_out_valid    = r_v;
    assign io_out_bits     = r_bits;
    assign io_out_grant_oh = r_oh;
    assign io_out_chosen   = r_idx;

endmodule
`default_nettype wire
